// File: rtl/wb_master_pkg.sv
// Shared types and constants for the Wishbone classic-cycle command master.
package wb_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WDATA,
    BUS,
    RHOLD,
    DONE
  } state_e;

  localparam logic [3:0] WB_SEL_ALL       = 4'hF;
  localparam int         WB_SLAVE_SEL_MSB = 31;
  localparam int         WB_SLAVE_SEL_LSB = 24;
  localparam int         WB_OFFSET_WIDTH  = 24;

  // Next word address: the slave-select byte is frozen, only the offset wraps.
  function automatic logic [31:0] nextWordAdr(input logic [31:0] adr);
    logic [WB_OFFSET_WIDTH-1:0] offset;
    offset = adr[WB_OFFSET_WIDTH-1:0] + WB_OFFSET_WIDTH'(1);
    return {adr[WB_SLAVE_SEL_MSB:WB_SLAVE_SEL_LSB], offset};
  endfunction

endpackage

// File: rtl/wb_master_timer.sv
// Bus-phase watchdog for the Wishbone master; the module only exists when
// WB_MASTER_TIMEOUT_EN is defined.
`ifdef WB_MASTER_TIMEOUT_EN
module wb_master_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the edge that would end the TIMEOUT_CYCLES-th unacknowledged cycle.
  assign expired_o = enable_i && (count_q == LAST_COUNT);

endmodule
`endif

// File: rtl/wishbone_master_ctrl.sv
// Command-driven Wishbone classic-cycle burst master. Define WB_MASTER_TIMEOUT_EN
// to build the no-acknowledge watchdog; otherwise BUS waits forever for ack.
module wishbone_master_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_stb_i,
  output logic                 cmd_rdy_o,
  input  logic                 cmd_we_i,
  input  logic [31:0]          cmd_adr_i,
  input  logic [CNT_WIDTH-1:0] cmd_cnt_i,
  input  logic                 wr_stb_i,
  output logic                 wr_rdy_o,
  input  logic [31:0]          wr_dat_i,
  output logic                 rd_stb_o,
  input  logic                 rd_ack_i,
  output logic [31:0]          rd_dat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_timeout_o,
  output logic                 int_o,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_int_i
);

  import wb_master_pkg::*;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [31:0]          adr_q, adr_d;
  logic [31:0]          wrDat_q, wrDat_d;
  logic [31:0]          rdDat_q, rdDat_d;
  logic                 we_q, we_d;
  logic                 cmdRdy_q, wrRdy_q, rdStb_q, busy_q, done_q, err_q, int_q;
  logic                 wbWe_q, cyc_q, stb_q;
  logic [3:0]           sel_q;
  logic                 expired;
  logic                 abort;
  logic                 lastWord;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_master_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q != BUS),
    .enable_i ((state_q == BUS) && !wb_ack_i),
    .expired_o(expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign lastWord = (remaining_q == CNT_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    adr_d       = adr_q;
    wrDat_d     = wrDat_q;
    rdDat_d     = rdDat_q;
    we_d        = we_q;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_stb_i && cmdRdy_q) begin
          we_d        = cmd_we_i;
          adr_d       = cmd_adr_i;
          remaining_d = (cmd_cnt_i == '0) ? CNT_WIDTH'(1) : cmd_cnt_i;
          state_d     = cmd_we_i ? WDATA : BUS;
        end
      end
      WDATA: begin
        if (wr_stb_i && wrRdy_q) begin
          wrDat_d = wr_dat_i;
          state_d = BUS;
        end
      end
      BUS: begin
        // An ack in the expiry cycle still completes the word.
        if (wb_ack_i) begin
          if (!we_q) begin
            rdDat_d = wb_dat_i;
            state_d = RHOLD;
          end else if (lastWord) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
            adr_d       = nextWordAdr(adr_q);
            state_d     = WDATA;
          end
        end else if (expired) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      RHOLD: begin
        if (rd_ack_i) begin
          if (lastWord) begin
            state_d = DONE;
          end else begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
            adr_d       = nextWordAdr(adr_q);
            state_d     = BUS;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output flop is loaded from the next state so it lines up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      adr_q       <= '0;
      wrDat_q     <= '0;
      rdDat_q     <= '0;
      we_q        <= 1'b0;
      cmdRdy_q    <= 1'b0;
      wrRdy_q     <= 1'b0;
      rdStb_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      int_q       <= 1'b0;
      wbWe_q      <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      adr_q       <= adr_d;
      wrDat_q     <= wrDat_d;
      rdDat_q     <= rdDat_d;
      we_q        <= we_d;
      cmdRdy_q    <= (state_d == IDLE);
      wrRdy_q     <= (state_d == WDATA);
      rdStb_q     <= (state_d == RHOLD);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      err_q       <= abort;
      int_q       <= wb_int_i;
      wbWe_q      <= (state_d == BUS) && we_d;
      cyc_q       <= (state_d == WDATA) || (state_d == BUS) || (state_d == RHOLD);
      stb_q       <= (state_d == BUS);
      sel_q       <= (state_d == BUS) ? WB_SEL_ALL : 4'h0;
    end
  end

  assign cmd_rdy_o     = cmdRdy_q;
  assign wr_rdy_o      = wrRdy_q;
  assign rd_stb_o      = rdStb_q;
  assign rd_dat_o      = rdDat_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign int_o         = int_q;
  assign wb_we_o       = wbWe_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_sel_o      = sel_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = wrDat_q;

endmodule

// File: tb/tb_wishbone_master_ctrl.sv
// Self-checking bench for wishbone_master_ctrl with a reactive slave, writer
// and read consumer; follows WB_MASTER_TIMEOUT_EN when it is defined.
module tb_wishbone_master_ctrl;

  localparam int CNT_W = 16;
  localparam int TMO   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_stb_i = 1'b0, cmd_we_i = 1'b0;
  logic [31:0]      cmd_adr_i = '0;
  logic [CNT_W-1:0] cmd_cnt_i = '0;
  logic             wr_stb_i = 1'b0;
  logic [31:0]      wr_dat_i = '0;
  logic             rd_ack_i = 1'b0;
  logic [31:0]      wb_dat_i = '0;
  logic             wb_ack_i = 1'b0, wb_int_i = 1'b0;
  logic             cmd_rdy_o, wr_rdy_o, rd_stb_o, busy_o, done_o, err_timeout_o, int_o;
  logic             wb_we_o, wb_cyc_o, wb_stb_o;
  logic [3:0]       wb_sel_o;
  logic [31:0]      rd_dat_o, wb_adr_o, wb_dat_o;

  wishbone_master_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_stb_i(cmd_stb_i), .cmd_rdy_o(cmd_rdy_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_cnt_i(cmd_cnt_i),
    .wr_stb_i(wr_stb_i), .wr_rdy_o(wr_rdy_o), .wr_dat_i(wr_dat_i),
    .rd_stb_o(rd_stb_o), .rd_ack_i(rd_ack_i), .rd_dat_o(rd_dat_o),
    .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o), .int_o(int_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_int_i(wb_int_i)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the burst should look like, and what the agents saw.
  logic [31:0] wrData[16];
  logic [31:0] rdData[16];
  logic [31:0] txAdr[$];
  logic [31:0] txDat[$];
  logic        txWe[$];
  logic [31:0] rdGot[$];
  int  nWords, wrIdx, txCount;
  int  waitMin, waitMax, waitTarget, waitCnt;
  int  holdMin, holdMax, holdTarget, holdCnt;
  int  doneSeen, errSeen, busyNoCyc, stbWhileHold, selBad, rdStbSeen;
  int  stepIdx = 0, firstStb, firstRdStb;
  bit  noAck = 1'b0, usePreset = 1'b0, intValid = 1'b0;
  logic intPrev = 1'b0;
  logic sStb, sWrRdy;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expAdr(input logic [31:0] base, input int i);
    int off;
    off = (int'(base[23:0]) + i) % 16777216;
    return (base & 32'hFF00_0000) | 32'(off);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " ctrl"}, 32'({cmd_rdy_o, wr_rdy_o, rd_stb_o, busy_o, done_o,
                err_timeout_o, int_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_sel_o}), 32'h0);
    checkOutput({tag, " rd_dat"}, rd_dat_o, 32'h0);
    checkOutput({tag, " wb_adr"}, wb_adr_o, 32'h0);
    checkOutput({tag, " wb_dat"}, wb_dat_o, 32'h0);
  endtask

  // One clock of every agent: observe at the falling edge, then drive.
  task automatic cycleStep();
    @(negedge clk);
    stepIdx++;
    sStb   = wb_stb_o;
    sWrRdy = wr_rdy_o;
    if (intValid) checkOutput("int_o lag", int_o, intPrev);
    if (busy_o) checkOutput("cmd_rdy while busy", cmd_rdy_o, 1'b0);
    if (done_o) doneSeen++;
    if (err_timeout_o) errSeen++;
    if (busy_o && !wb_cyc_o) busyNoCyc++;
    if (rd_stb_o && wb_stb_o) stbWhileHold++;
    if (rd_stb_o) rdStbSeen++;
    if (wb_sel_o !== (wb_stb_o ? 4'hF : 4'h0)) selBad++;
    if (wb_stb_o && firstStb < 0) firstStb = stepIdx;
    if (rd_stb_o && firstRdStb < 0) firstRdStb = stepIdx;
    wb_ack_i = 1'b0;
    if (wb_stb_o && !noAck) begin
      if (waitCnt >= waitTarget) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rdData[txCount % 16];
        txAdr.push_back(wb_adr_o);
        txDat.push_back(wb_dat_o);
        txWe.push_back(wb_we_o);
        txCount++;
        waitCnt = 0;
        waitTarget = $urandom_range(waitMax, waitMin);
      end else begin
        waitCnt++;
      end
    end
    rd_ack_i = 1'b0;
    if (rd_stb_o) begin
      if (holdCnt >= holdTarget) begin
        rd_ack_i = 1'b1;
        rdGot.push_back(rd_dat_o);
        holdCnt = 0;
        holdTarget = $urandom_range(holdMax, holdMin);
      end else begin
        holdCnt++;
      end
    end
    wr_stb_i = 1'b0;
    if (wr_rdy_o && wrIdx < nWords && $urandom_range(3, 0) != 0) begin
      wr_stb_i = 1'b1;
      wr_dat_i = wrData[wrIdx];
      wrIdx++;
    end
    cmd_stb_i = busy_o && ($urandom_range(1, 0) == 1);
    cmd_we_i  = 1'($urandom);
    cmd_adr_i = $urandom;
    cmd_cnt_i = CNT_W'($urandom_range(7, 0));
    wb_int_i  = 1'($urandom);
    intPrev   = wb_int_i;
    intValid  = 1'b1;
  endtask

  task automatic applyStimulus(input bit we, input logic [31:0] adr, input int cnt);
    @(negedge clk);
    checkOutput("cmd_rdy idle", cmd_rdy_o, 1'b1);
    checkOutput("busy idle", busy_o, 1'b0);
    cmd_stb_i = 1'b1;
    cmd_we_i  = we;
    cmd_adr_i = adr;
    cmd_cnt_i = CNT_W'(cnt);
  endtask

  task automatic startBurst(input bit we, input logic [31:0] adr, input int cnt,
                            input int wMin, input int wMax, input int hMin, input int hMax);
    nWords = (cnt == 0) ? 1 : cnt;
    wrIdx = 0; txCount = 0;
    txAdr.delete(); txDat.delete(); txWe.delete(); rdGot.delete();
    doneSeen = 0; errSeen = 0; busyNoCyc = 0; stbWhileHold = 0; selBad = 0; rdStbSeen = 0;
    firstStb = -1; firstRdStb = -1;
    waitMin = wMin; waitMax = wMax; waitTarget = $urandom_range(wMax, wMin); waitCnt = 0;
    holdMin = hMin; holdMax = hMax; holdTarget = $urandom_range(hMax, hMin); holdCnt = 0;
    if (!usePreset) begin
      for (int i = 0; i < 16; i++) begin
        wrData[i] = $urandom;
        rdData[i] = $urandom;
      end
    end
    usePreset = 1'b0;
    applyStimulus(we, adr, cnt);
    cycleStep();
    if (we) checkOutput("wr_rdy after accept", sWrRdy, 1'b1);
    else    checkOutput("stb after accept", sStb, 1'b1);
  endtask

  task automatic runBurst(input bit we, input logic [31:0] adr, input int cnt,
                          input int wMin, input int wMax, input int hMin, input int hMax);
    int budget;
    startBurst(we, adr, cnt, wMin, wMax, hMin, hMax);
    budget = 0;
    while (doneSeen == 0 && errSeen == 0 && budget < 2000) begin
      cycleStep();
      budget++;
    end
    checkOutput("word count", txCount, nWords);
    for (int i = 0; i < txCount && i < nWords; i++) begin
      checkOutput("word address", txAdr[i], expAdr(adr, i));
      checkOutput("word we", 32'(txWe[i]), 32'(we));
      if (we) checkOutput("write data", txDat[i], wrData[i]);
    end
    if (!we) begin
      checkOutput("read word count", rdGot.size(), nWords);
      for (int i = 0; i < rdGot.size() && i < nWords; i++)
        checkOutput("read data", rdGot[i], rdData[i]);
      checkOutput("stb low while rd held", stbWhileHold, 0);
    end
    checkOutput("done pulses", doneSeen, 1);
    checkOutput("timeout pulses", errSeen, 0);
    checkOutput("cyc gap cycles", busyNoCyc, 1);
    checkOutput("sel tracks stb", selBad, 0);
    cycleStep();
    checkOutput("busy after done", busy_o, 1'b0);
    checkOutput("cyc after done", wb_cyc_o, 1'b0);
    checkOutput("done one cycle", done_o, 1'b0);
  endtask

  task automatic doReset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero(tag);
    cmd_stb_i = 1'b0; wr_stb_i = 1'b0; wb_ack_i = 1'b0; rd_ack_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    intValid = 1'b0;
    noAck = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stbRun;
    logic [31:0] adr;
    $display("[TB] start");
    #1 rst = 1'b1;
    @(negedge clk);
    checkAllZero("reset state");
    @(negedge clk);
    rst = 1'b0;

    // Single zero-wait read, count 0 treated as one word.
    usePreset = 1'b1;
    rdData[0] = 32'hCAFEF00D;
    runBurst(1'b0, 32'h01000010, 0, 0, 0, 0, 0);
    checkOutput("zero-wait rd_stb latency", firstRdStb - firstStb, 1);

    // Write burst of three words with two wait states each.
    usePreset = 1'b1;
    wrData[0] = 32'd1; wrData[1] = 32'd2; wrData[2] = 32'd3;
    runBurst(1'b1, 32'h00000004, 3, 2, 2, 0, 0);

    // Read burst across the offset wrap with a slow consumer.
    runBurst(1'b0, 32'h01FFFFFF, 2, 0, 0, 5, 5);

    // Ack arriving in the last permitted cycle completes normally.
    runBurst(1'b0, 32'h02000100, 1, TMO - 1, TMO - 1, 0, 0);

    // Slave that never acknowledges.
    noAck = 1'b1;
    startBurst(1'b0, 32'h03000000, 1, 0, 0, 0, 0);
    stbRun = 1;
`ifdef WB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 100 && wb_stb_o; i++) begin
      cycleStep();
      if (wb_stb_o) stbRun++;
    end
    checkOutput("timeout stb cycles", stbRun, TMO);
    checkOutput("timeout pulse", errSeen, 1);
    checkOutput("timeout no done", doneSeen, 0);
    checkOutput("timeout no rd_stb", rdStbSeen, 0);
    cycleStep();
    checkOutput("timeout back idle", busy_o, 1'b0);
    checkOutput("timeout pulse width", err_timeout_o, 1'b0);
    checkOutput("timeout cyc low", wb_cyc_o, 1'b0);
    noAck = 1'b0;
`else
    for (int i = 0; i < 40; i++) begin
      cycleStep();
      if (wb_stb_o) stbRun++;
    end
    checkOutput("no-timeout stb held", stbRun, 41);
    checkOutput("no-timeout err tied", errSeen, 0);
    doReset("reset from hang");
`endif

    // Asynchronous reset while word 2 of 4 is on the bus.
    startBurst(1'b0, 32'h04000020, 4, 1, 1, 0, 0);
    for (int i = 0; i < 200 && !(txCount == 1 && wb_stb_o); i++) cycleStep();
    checkOutput("reached word 2", txCount, 1);
    doReset("reset mid-burst");
    runBurst(1'b1, 32'h05000040, 2, 0, 1, 0, 0);

    // Randomised bursts, biased towards the offset wrap.
    for (int k = 0; k < 14; k++) begin
      adr = $urandom;
      if ($urandom_range(2, 0) == 0) adr[23:0] = 24'hFFFFFF - 24'($urandom_range(3, 0));
      runBurst(1'($urandom), adr, $urandom_range(6, 0), 0, 3, 0, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
